// File: rtl/fp_align_operands.sv
// FP add/sub alignment stage: orders two IEEE-754 singles by magnitude and right-shifts the smaller
// significand to the common exponent with guard/round/sticky. Define FP_ALIGN_FAST_EN for a one-cycle barrel shift.
module fp_align_operands #(
  parameter int MANT_W = 27,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] mant_big,
  output logic [MANT_W-1:0] mant_small,
  output logic              sign_big,
  output logic              sign_small,
  output logic [EXP_W-1:0]  exp_common,
  output logic              swapped,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer occurs on a rising edge where valid && ready are both 1;
  // valid never depends combinationally on ready, and a held result stays stable while ready=0.
  typedef enum logic [1:0] {S_IDLE, S_CMP, S_SHIFT, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [31:0]       r_op_a, r_op_b;
  logic [MANT_W-1:0] r_mant_big, r_mant_small;
  logic              r_sign_big, r_sign_small, r_swapped;
  logic [EXP_W-1:0]  r_exp_common;

  logic [EXP_W-1:0]  w_exp_a, w_exp_b, w_exp_big, w_exp_small, w_diff;
  logic [MANT_W-1:0] w_sig_a, w_sig_b, w_sig_big, w_sig_small, w_flush;
  logic              w_a_big, w_far;

  // Denormals take effective exponent 1 with a zero hidden bit.
  assign w_exp_a = (r_op_a[30:23] == '0) ? EXP_W'(1) : r_op_a[30:23];
  assign w_exp_b = (r_op_b[30:23] == '0) ? EXP_W'(1) : r_op_b[30:23];
  assign w_sig_a = {|r_op_a[30:23], r_op_a[22:0], 3'b000};
  assign w_sig_b = {|r_op_b[30:23], r_op_b[22:0], 3'b000};

  assign w_a_big     = (w_exp_a > w_exp_b) || ((w_exp_a == w_exp_b) && (w_sig_a >= w_sig_b));
  assign w_exp_big   = w_a_big ? w_exp_a : w_exp_b;
  assign w_exp_small = w_a_big ? w_exp_b : w_exp_a;
  assign w_sig_big   = w_a_big ? w_sig_a : w_sig_b;
  assign w_sig_small = w_a_big ? w_sig_b : w_sig_a;
  assign w_diff      = w_exp_big - w_exp_small;
  assign w_far       = (w_diff >= EXP_W'(MANT_W));
  assign w_flush     = {{(MANT_W-1){1'b0}}, |w_sig_small};

`ifdef FP_ALIGN_FAST_EN
  logic [2*MANT_W-1:0] w_wide;
  logic [MANT_W-1:0]   w_shifted;
  // Bits shifted below the significand collapse into the sticky bit.
  assign w_wide    = {w_sig_small, {MANT_W{1'b0}}} >> w_diff;
  assign w_shifted = w_wide[2*MANT_W-1:MANT_W] | {{(MANT_W-1){1'b0}}, |w_wide[MANT_W-1:0]};
`else
  logic [4:0] r_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_CMP;
`ifdef FP_ALIGN_FAST_EN
      S_CMP:   w_next = S_DONE;
      S_SHIFT: w_next = S_DONE;
`else
      S_CMP:   w_next = ((w_diff == '0) || w_far) ? S_DONE : S_SHIFT;
      S_SHIFT: if (r_cnt == 5'd1) w_next = S_DONE;
`endif
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_mant_big   <= '0;
      r_mant_small <= '0;
      r_sign_big   <= 1'b0;
      r_sign_small <= 1'b0;
      r_swapped    <= 1'b0;
      r_exp_common <= '0;
`ifndef FP_ALIGN_FAST_EN
      r_cnt        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op_a <= op_a;
          r_op_b <= op_b;
        end
        S_CMP: begin
          r_mant_big   <= w_sig_big;
          r_exp_common <= w_exp_big;
          r_sign_big   <= w_a_big ? r_op_a[31] : r_op_b[31];
          r_sign_small <= w_a_big ? r_op_b[31] : r_op_a[31];
          r_swapped    <= ~w_a_big;
`ifdef FP_ALIGN_FAST_EN
          r_mant_small <= w_far ? w_flush : w_shifted;
`else
          r_mant_small <= w_far ? w_flush : w_sig_small;
          r_cnt        <= w_diff[4:0];
`endif
        end
`ifndef FP_ALIGN_FAST_EN
        S_SHIFT: begin
          r_mant_small <= {1'b0, r_mant_small[MANT_W-1:2], r_mant_small[1] | r_mant_small[0]};
          r_cnt        <= r_cnt - 5'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign mant_big   = r_mant_big;
  assign mant_small = r_mant_small;
  assign sign_big   = r_sign_big;
  assign sign_small = r_sign_small;
  assign exp_common = r_exp_common;
  assign swapped    = r_swapped;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_fp_align_operands.sv
// Directed-vector bench for fp_align_operands: driver pushes hand-computed results into a queue,
// a negedge monitor pops and compares them at each output handshake, including edge latency.
module tb_fp_align_operands;

  localparam int W = 73;  // {lat[7:0], swapped, exp[7:0], sign_small, sign_big, mant_small[26:0], mant_big[26:0]}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [26:0] mant_big, mant_small;
  logic        sign_big, sign_small, swapped;
  logic [7:0]  exp_common;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int acc_edge = 0;
  int obs_lat = 0;
  bit seen = 0;

  fp_align_operands dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .mant_big(mant_big), .mant_small(mant_small), .sign_big(sign_big),
    .sign_small(sign_small), .exp_common(exp_common), .swapped(swapped),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [26:0] mb, input logic [26:0] ms,
                                        input logic sb, input logic ss, input logic [7:0] ex,
                                        input logic sw, input int lat_slow);
    logic [7:0] lat;
`ifdef FP_ALIGN_FAST_EN
    lat = 8'd1;
`else
    lat = 8'(lat_slow);
`endif
    return {lat, sw, ex, ss, sb, ms, mb};
  endfunction

  // Monitor: latency measured from accept edge to the edge where out_valid rose.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (!out_valid) seen = 0;
      if (out_valid && !seen) begin
        seen = 1;
        obs_lat = edge_cnt - acc_edge;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("mant_big",   32'(mant_big),   32'(e[26:0]));
          chk("mant_small", 32'(mant_small), 32'(e[53:27]));
          chk("sign_big",   32'(sign_big),   32'(e[54]));
          chk("sign_small", 32'(sign_small), 32'(e[55]));
          chk("exp_common", 32'(exp_common), 32'(e[63:56]));
          chk("swapped",    32'(swapped),    32'(e[64]));
          chk("latency",    32'(obs_lat),    32'(e[72:65]));
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [W-1:0] e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    acc_edge = edge_cnt;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    #2;
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_mant_small", 32'(mant_small), 32'd0);
    chk("rst_mant_big",   32'(mant_big),   32'd0);
    chk("rst_exp_common", 32'(exp_common), 32'd0);
    chk("rst_state",      32'(dbg_state),  32'd0);
    #20;
    rst_n = 1'b1;

    // Shift by 1, B larger
    send(32'h3F800000, 32'h40000000, pack(27'h4000000, 27'h2000000, 0, 0, 8'h80, 1, 2)); drain();
    // Sticky accumulation over 4 shifts
    send(32'h41800000, 32'h3F800001, pack(27'h4000000, 27'h0400001, 0, 0, 8'h83, 0, 5)); drain();
    // Flush at diff 28 and at boundary diff 27
    send(32'h4B800000, 32'h3D800001, pack(27'h4000000, 27'h0000001, 0, 0, 8'h97, 0, 1)); drain();
    send(32'h4D000000, 32'h3F800000, pack(27'h4000000, 27'h0000001, 0, 0, 8'h9A, 0, 1)); drain();
    // Longest iterative shifts: diff 26 and diff 25
    send(32'h4C800000, 32'h3F800000, pack(27'h4000000, 27'h0000001, 0, 0, 8'h99, 0, 27)); drain();
    send(32'h4C000000, 32'h3FC00000, pack(27'h4000000, 27'h0000003, 0, 0, 8'h98, 0, 26)); drain();
    // Equal exponents, B larger significand
    send(32'h3F800000, 32'h3FC00000, pack(27'h6000000, 27'h4000000, 0, 0, 8'h7F, 1, 1)); drain();
    // Equal exponents, A larger, B negative
    send(32'h40400000, 32'hC0000000, pack(27'h6000000, 27'h4000000, 0, 1, 8'h80, 0, 1)); drain();
    // Full magnitude tie: A wins, signs follow
    send(32'hBF800000, 32'h3F800000, pack(27'h4000000, 27'h4000000, 1, 0, 8'h7F, 0, 1)); drain();
    // Denormal against smallest normal
    send(32'h00000004, 32'h00800000, pack(27'h4000000, 27'h0000020, 0, 0, 8'h01, 1, 1)); drain();

    // Backpressure: result held for 5 cycles, busy-time input ignored
    out_ready = 1'b0;
    send(32'h41800000, 32'h3F800001, pack(27'h4000000, 27'h0400001, 0, 0, 8'h83, 0, 5));
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_wait", 32'(out_valid), 32'd1);
    in_valid = 1'b1;
    op_a = 32'h12345678;
    op_b = 32'h7F000000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready",   32'(in_ready),   32'd0);
      chk("bp_out_valid",  32'(out_valid),  32'd1);
      chk("bp_mant_small", 32'(mant_small), 32'h0400001);
      chk("bp_exp_common", 32'(exp_common), 32'h83);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("post_hs_in_ready",  32'(in_ready),  32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset while busy (mid-SHIFT in the iterative build)
    out_ready = 1'b0;
    send(32'h4C800000, 32'h3F800000, pack(27'h4000000, 27'h0000001, 0, 0, 8'h99, 0, 27));
    @(negedge clk);
    @(negedge clk);
`ifndef FP_ALIGN_FAST_EN
    chk("mid_shift_state", 32'(dbg_state), 32'd2);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid",  32'(out_valid),  32'd0);
    chk("arst_in_ready",   32'(in_ready),   32'd1);
    chk("arst_mant_small", 32'(mant_small), 32'd0);
    chk("arst_mant_big",   32'(mant_big),   32'd0);
    chk("arst_state",      32'(dbg_state),  32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    #15;
    rst_n = 1'b1;

    // Recovery after reset
    send(32'h3F800000, 32'h40000000, pack(27'h4000000, 27'h2000000, 0, 0, 8'h80, 1, 2)); drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_align_operands.md
Name: fp_align_operands

Overview:
- Front-end alignment stage of the FP add/sub datapath. It is the inverse of the normalizer: it shifts the smaller operand right to a common exponent, where the normalizer shifts the result back.
- Unpacks two IEEE-754 single operands and orders them by magnitude.
- Right-shifts the smaller significand to the larger exponent, accumulating guard/round/sticky bits.
- Delivers 27-bit aligned significands plus the common exponent to the adder, which feeds the normalizer.

Parameters:
- MANT_W, 27, aligned significand width: [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
- EXP_W, 8, exponent width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair.
- op_a  in  32  IEEE-754 single operand A.
- op_b  in  32  IEEE-754 single operand B.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts the result.
- mant_big  out  27  significand of the larger-magnitude operand, unshifted.
- mant_small  out  27  aligned significand of the smaller operand.
- sign_big  out  1  sign of the larger operand.
- sign_small  out  1  sign of the smaller operand.
- exp_common  out  8  common (larger) exponent.
- swapped  out  1  1 when B is the larger operand.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - All data outputs and internal counters clear to 0.
  - Reset takes effect immediately, including mid-SHIFT.
- Unpack:
  - exp field 0 -> hidden bit 0, effective exponent 1.
  - Otherwise hidden bit 1, effective exponent = field.
  - sig = {hidden, frac, 3'b000}.
  - Exponent 255 is treated numerically; special values are handled by separate logic.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register op_a/op_b, drop in_ready, go to CMP.
- CMP (1 cycle):
  - big = operand with larger effective exponent.
  - On equal exponents, big = operand with larger sig; on full tie, big=A, swapped=0.
  - Load mant_big, exp_common, signs, swapped; mant_small = small sig; diff = exp_big - exp_small.
  - diff==0 -> DONE.
  - diff>=27 -> mant_small = {26'b0, |small_sig} (flush to sticky), then DONE.
  - 1<=diff<=26 -> cnt=diff, go to SHIFT.
- SHIFT:
  - Each cycle: mant_small = {1'b0, mant_small[26:1]} with bit0 = old bit1 | old bit0; cnt--.
  - When cnt reaches 1 on this edge, go to DONE.
- DONE:
  - out_valid=1; all outputs held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid=0, in_ready=1, state=IDLE.
  - No new pair is accepted in the same cycle as the output handshake.
- Latency:
  - The accept edge is edge 0; out_valid rises at edge 1+s.
  - s = diff for 1<=diff<=26, otherwise s=0.
- Throughput: one pair in flight; in_ready=0 from accept until output handshake.
- in_valid while busy is ignored; the upstream stage holds its data until in_ready.

Optional Feature:
- FP_ALIGN_FAST_EN defined:
  - CMP performs the full barrel shift plus sticky OR of all shifted-out bits in one cycle.
  - SHIFT state is never entered.
  - out_valid always rises at edge 1.
- Undefined: iterative 1-bit-per-cycle SHIFT as above.
- Output values are bit-identical in both builds.

Test Plan:
- Shift by 1: a=0x3F800000, b=0x40000000 -> swapped=1, exp_common=0x80, mant_big=0x4000000, mant_small=0x2000000, out_valid at edge 2 (edge 1 fast).
- Sticky: a=0x41800000, b=0x3F800001 -> exp_common=0x83, mant_small=0x0400001 (sticky set), swapped=0, out_valid at edge 5.
- Flush: a=0x4B800000, b=0x3D800001 (diff 28) -> mant_small=0x0000001, mant_big=0x4000000, out_valid at edge 1.
- Equal exponents: a=0x3F800000, b=0x3FC00000 -> swapped=1, mant_big=0x6000000, mant_small=0x4000000, exp_common=0x7F, edge 1.
- Denormal: a=0x00000004, b=0x00800000 -> exp_common=0x01, mant_big=0x4000000, mant_small=0x0000020, edge 1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
  - Assert rst_n=0 mid-SHIFT -> out_valid=0 and in_ready=1 immediately, with no clock edge required.
